// File: rtl/mem_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_req_arbiter_if : shared types plus the icache/dcache/memory bus bundle
//                      of the memory request arbiter.
// Revision: 1.0
// ============================================================================

package params_pkg;
  localparam int ADDR_WIDTH = 32;
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_LINE = 2'd3
  } access_size_t;
endpackage

interface mem_req_arbiter_if #(
  parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = 128
);
  logic                     ic_req_valid_i;
  logic [ADDR_WIDTH-1:0]    ic_addr_i;
  params_pkg::access_size_t ic_access_size_i;
  logic                     ic_req_ready_o;
  logic                     ic_resp_valid_o;
  logic [DATA_WIDTH-1:0]    ic_resp_data_o;

  logic                     dc_req_valid_i;
  logic                     dc_req_wr_i;
  logic [ADDR_WIDTH-1:0]    dc_addr_i;
  logic [DATA_WIDTH-1:0]    dc_wr_data_i;
  params_pkg::access_size_t dc_access_size_i;
  logic                     dc_req_ready_o;
  logic                     dc_resp_valid_o;
  logic [DATA_WIDTH-1:0]    dc_resp_data_o;
  logic                     dc_wr_done_o;

  logic                     rd_req_valid_o;
  logic                     wr_req_valid_o;
  logic                     req_is_instr_o;
  logic [ADDR_WIDTH-1:0]    address_o;
  logic [DATA_WIDTH-1:0]    wr_data_o;
  params_pkg::access_size_t access_size_o;
  logic                     data_valid_i;
  logic                     data_is_instr_i;
  logic [DATA_WIDTH-1:0]    data_i;
  logic                     timeout_o;

  // Arbiter side
  modport slave (
    input  ic_req_valid_i, ic_addr_i, ic_access_size_i,
    output ic_req_ready_o, ic_resp_valid_o, ic_resp_data_o,
    input  dc_req_valid_i, dc_req_wr_i, dc_addr_i, dc_wr_data_i, dc_access_size_i,
    output dc_req_ready_o, dc_resp_valid_o, dc_resp_data_o, dc_wr_done_o,
    output rd_req_valid_o, wr_req_valid_o, req_is_instr_o, address_o, wr_data_o,
    output access_size_o, timeout_o,
    input  data_valid_i, data_is_instr_i, data_i
  );

  // Cache and memory side
  modport master (
    output ic_req_valid_i, ic_addr_i, ic_access_size_i,
    input  ic_req_ready_o, ic_resp_valid_o, ic_resp_data_o,
    output dc_req_valid_i, dc_req_wr_i, dc_addr_i, dc_wr_data_i, dc_access_size_i,
    input  dc_req_ready_o, dc_resp_valid_o, dc_resp_data_o, dc_wr_done_o,
    input  rd_req_valid_o, wr_req_valid_o, req_is_instr_o, address_o, wr_data_o,
    input  access_size_o, timeout_o,
    output data_valid_i, data_is_instr_i, data_i
  );
endinterface

`default_nettype wire

// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// mem_req_arbiter : round-robin icache/dcache arbiter with a single request in
//                   flight, response routing by owner tag and read timeout.
// Revision: 1.0
// ============================================================================

module mem_req_arbiter #(
  parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = 128,
  parameter int WR_LATENCY = 6,
  parameter int TIMEOUT    = 32
) (
  input  wire              clk_i,
  input  wire              rst_i,
  mem_req_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RD_WAIT = 2'd2,
    S_WR_WAIT = 2'd3
  } state_t;

  localparam int c_CNT_MAX = (TIMEOUT > WR_LATENCY) ? TIMEOUT : WR_LATENCY;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX);
  localparam logic [c_CNT_W-1:0] c_RD_LAST = c_CNT_W'(TIMEOUT - 1);
  // The counter starts one cycle after issue, so the write-done decision
  // lands two counts short of WR_LATENCY to pulse at issue + WR_LATENCY.
  localparam logic [c_CNT_W-1:0] c_WR_LAST = c_CNT_W'(WR_LATENCY - 2);

  state_t                   r_state, w_next_state;
  logic [c_CNT_W-1:0]       r_cnt;
  logic                     r_owner_ic, r_is_wr, r_last_ic;
  logic                     w_grant_ic, w_grant_dc, w_hs_wr;
  logic                     w_match, w_rd_abort, w_wr_done;

  logic                     r_rd_req_valid, r_wr_req_valid, r_req_is_instr;
  logic [ADDR_WIDTH-1:0]    r_address;
  logic [DATA_WIDTH-1:0]    r_wr_data, r_ic_resp_data, r_dc_resp_data;
  params_pkg::access_size_t r_access_size;
  logic                     r_ic_resp_valid, r_dc_resp_valid, r_dc_wr_done, r_timeout;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_grant_ic   = 1'b0;
    w_grant_dc   = 1'b0;
    w_match      = 1'b0;
    w_rd_abort   = 1'b0;
    w_wr_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Ready is gated by reset so nothing is granted while it is held
        w_grant_ic = rst_i & bus.ic_req_valid_i & (~bus.dc_req_valid_i | ~r_last_ic);
        w_grant_dc = rst_i & bus.dc_req_valid_i & (~bus.ic_req_valid_i | r_last_ic);
        if (w_grant_ic | w_grant_dc) w_next_state = S_ISSUE;
      end
      S_ISSUE: w_next_state = r_is_wr ? S_WR_WAIT : S_RD_WAIT;
      S_RD_WAIT: begin
        w_match    = bus.data_valid_i & (bus.data_is_instr_i == r_owner_ic);
        w_rd_abort = ~w_match & (r_cnt == c_RD_LAST);
        if (w_match | w_rd_abort) w_next_state = S_IDLE;
      end
      S_WR_WAIT: begin
        w_wr_done = (r_cnt == c_WR_LAST);
        if (w_wr_done) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_hs_wr = w_grant_dc & bus.dc_req_wr_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt           <= '0;
      r_owner_ic      <= 1'b0;
      r_is_wr         <= 1'b0;
      r_last_ic       <= 1'b1;
      r_rd_req_valid  <= 1'b0;
      r_wr_req_valid  <= 1'b0;
      r_req_is_instr  <= 1'b0;
      r_address       <= '0;
      r_wr_data       <= '0;
      r_access_size   <= params_pkg::SZ_BYTE;
      r_ic_resp_valid <= 1'b0;
      r_ic_resp_data  <= '0;
      r_dc_resp_valid <= 1'b0;
      r_dc_resp_data  <= '0;
      r_dc_wr_done    <= 1'b0;
      r_timeout       <= 1'b0;
    end else begin
      // Memory request fields live only for the single ISSUE cycle
      r_rd_req_valid  <= 1'b0;
      r_wr_req_valid  <= 1'b0;
      r_req_is_instr  <= 1'b0;
      r_address       <= '0;
      r_wr_data       <= '0;
      r_access_size   <= params_pkg::SZ_BYTE;
      r_ic_resp_valid <= 1'b0;
      r_dc_resp_valid <= 1'b0;
      r_dc_wr_done    <= w_wr_done;
      r_timeout       <= w_rd_abort;

      if (w_grant_ic | w_grant_dc) begin
        r_owner_ic     <= w_grant_ic;
        r_is_wr        <= w_hs_wr;
        r_last_ic      <= w_grant_ic;
        r_rd_req_valid <= ~w_hs_wr;
        r_wr_req_valid <= w_hs_wr;
        r_req_is_instr <= w_grant_ic;
        r_address      <= w_grant_ic ? bus.ic_addr_i : bus.dc_addr_i;
        r_access_size  <= w_grant_ic ? bus.ic_access_size_i : bus.dc_access_size_i;
        r_wr_data      <= w_hs_wr ? bus.dc_wr_data_i : '0;
      end

      if (r_state == S_ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == S_RD_WAIT || r_state == S_WR_WAIT) begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end

      if (w_match) begin
        if (r_owner_ic) begin
          r_ic_resp_valid <= 1'b1;
          r_ic_resp_data  <= bus.data_i;
        end else begin
          r_dc_resp_valid <= 1'b1;
          r_dc_resp_data  <= bus.data_i;
        end
      end
    end
  end

  assign bus.ic_req_ready_o  = w_grant_ic;
  assign bus.dc_req_ready_o  = w_grant_dc;
  assign bus.ic_resp_valid_o = r_ic_resp_valid;
  assign bus.ic_resp_data_o  = r_ic_resp_data;
  assign bus.dc_resp_valid_o = r_dc_resp_valid;
  assign bus.dc_resp_data_o  = r_dc_resp_data;
  assign bus.dc_wr_done_o    = r_dc_wr_done;
  assign bus.rd_req_valid_o  = r_rd_req_valid;
  assign bus.wr_req_valid_o  = r_wr_req_valid;
  assign bus.req_is_instr_o  = r_req_is_instr;
  assign bus.address_o       = r_address;
  assign bus.wr_data_o       = r_wr_data;
  assign bus.access_size_o   = r_access_size;
  assign bus.timeout_o       = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_req_arbiter : directed and randomized transactions against a
//                      transaction-level model and a 10-stage memory.
// Revision: 1.0
// ============================================================================

module tb_mem_req_arbiter;
  import params_pkg::*;

  localparam int AW      = 32;
  localparam int DW      = 128;
  localparam int WR_LAT  = 6;
  localparam int TMO     = 32;
  localparam int MEM_LAT = 10;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_req_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WR_LATENCY(WR_LAT), .TIMEOUT(TMO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Initial memory image: byte i of line a holds (a - 0x40 + i)
  function automatic logic [DW-1:0] init_line(input logic [AW-1:0] a);
    logic [DW-1:0] l;
    for (int i = 0; i < 16; i++) l[i*8 +: 8] = 8'(a + AW'(i) - AW'('h40));
    return l;
  endfunction

  function automatic logic [3:0] pulses_now();
    return {bus.ic_resp_valid_o, bus.dc_resp_valid_o, bus.dc_wr_done_o, bus.timeout_o};
  endfunction

  // ---------------- memory environment ----------------
  typedef struct {
    int            due;
    logic          tag;
    logic [DW-1:0] data;
  } ret_t;

  ret_t          pq[$];
  logic [DW-1:0] env_mem [logic [AW-1:0]];
  bit            env_suppress = 1'b0;
  bit            inj_req = 1'b0;
  logic          inj_tag = 1'b0;

  initial begin : env
    ret_t r;
    bus.data_valid_i    = 1'b0;
    bus.data_is_instr_i = 1'b0;
    bus.data_i          = '0;
    forever begin
      @(negedge clk);
      bus.data_valid_i    = 1'b0;
      bus.data_is_instr_i = 1'b0;
      bus.data_i          = '0;
      if (pq.size() > 0 && pq[0].due == cyc) begin
        r = pq.pop_front();
        if (!env_suppress) begin
          bus.data_valid_i    = 1'b1;
          bus.data_is_instr_i = r.tag;
          bus.data_i          = r.data;
        end
      end else if (inj_req) begin
        bus.data_valid_i    = 1'b1;
        bus.data_is_instr_i = inj_tag;
        bus.data_i          = {$urandom, $urandom, $urandom, $urandom};
        inj_req             = 1'b0;
      end
      if (bus.rd_req_valid_o) begin
        r.due  = cyc + MEM_LAT;
        r.tag  = bus.req_is_instr_o;
        r.data = env_mem.exists(bus.address_o) ? env_mem[bus.address_o] : init_line(bus.address_o);
        pq.push_back(r);
      end
      if (bus.wr_req_valid_o) env_mem[bus.address_o] = bus.wr_data_o;
    end
  end

  // ---------------- requesters and reference model ----------------
  bit            ic_pend = 1'b0, dc_pend = 1'b0, dc_wr = 1'b0;
  logic [AW-1:0] ic_a = '0, dc_a = '0;
  access_size_t  ic_sz = SZ_BYTE, dc_sz = SZ_BYTE;
  logic [DW-1:0] dc_d = '0;
  bit            m_last_ic = 1'b1;
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  task automatic drive_ports();
    bus.ic_req_valid_i   = ic_pend;
    bus.ic_addr_i        = ic_a;
    bus.ic_access_size_i = ic_sz;
    bus.dc_req_valid_i   = dc_pend;
    bus.dc_req_wr_i      = dc_wr;
    bus.dc_addr_i        = dc_a;
    bus.dc_wr_data_i     = dc_d;
    bus.dc_access_size_i = dc_sz;
  endtask

  // Called at a falling edge while the arbiter is idle; runs one request to completion.
  task automatic txn(input int stray_at, output bit won_ic, output logic [DW-1:0] got);
    bit            exp_ic, exp_dc, wr, exp_to, busy_bad;
    logic [AW-1:0] a;
    access_size_t  sz;
    logic [DW-1:0] d, exp_d;
    logic [3:0]    pulses, exp_pulses;
    int            t0, lat;
    won_ic = 1'b0;
    got    = '0;
    drive_ports();
    #1;
    exp_ic = ic_pend && (!dc_pend || !m_last_ic);
    exp_dc = dc_pend && !exp_ic;
    check("ic_ready", bus.ic_req_ready_o, exp_ic);
    check("dc_ready", bus.dc_req_ready_o, exp_dc);
    won_ic = bus.ic_req_ready_o;
    if (!exp_ic && !exp_dc) return;
    wr = exp_dc && dc_wr;
    a  = exp_ic ? ic_a : dc_a;
    sz = exp_ic ? ic_sz : dc_sz;
    d  = wr ? dc_d : '0;
    m_last_ic = exp_ic;
    if (exp_ic) ic_pend = 1'b0; else dc_pend = 1'b0;
    exp_to = env_suppress && !wr;
    if (wr) ref_mem[a] = d;
    exp_d = ref_mem.exists(a) ? ref_mem[a] : init_line(a);
    t0 = cyc;

    @(negedge clk);
    drive_ports();
    check("rd_req", bus.rd_req_valid_o, !wr);
    check("wr_req", bus.wr_req_valid_o, wr);
    check("req_is_instr", bus.req_is_instr_o, exp_ic);
    check("address", bus.address_o, a);
    check("access_size", bus.access_size_o, sz);
    check("wr_data", bus.wr_data_o, d);

    busy_bad = 1'b0;
    pulses   = '0;
    lat      = 0;
    for (int k = 0; k < TMO + 12; k++) begin
      @(negedge clk);
      lat = cyc - t0;
      if (stray_at != 0 && lat == stray_at) begin
        inj_req = 1'b1;
        inj_tag = wr ? 1'b0 : !exp_ic;
      end
      pulses = pulses_now();
      if (pulses != 4'b0) break;
      if (bus.ic_req_ready_o || bus.dc_req_ready_o || bus.rd_req_valid_o || bus.wr_req_valid_o)
        busy_bad = 1'b1;
    end
    exp_pulses = exp_to ? 4'b0001 : wr ? 4'b0010 : exp_ic ? 4'b1000 : 4'b0100;
    check("resp_port", pulses, exp_pulses);
    check("resp_latency", lat, exp_to ? TMO + 2 : wr ? WR_LAT + 1 : MEM_LAT + 2);
    check("busy_quiet", busy_bad, 1'b0);
    if (!exp_to && !wr) begin
      got = exp_ic ? bus.ic_resp_data_o : bus.dc_resp_data_o;
      check("resp_data", got, exp_d);
    end
  endtask

  task automatic new_ic();
    ic_pend = 1'b1;
    ic_a    = AW'($urandom_range(0, 63)) << 4;
    ic_sz   = access_size_t'($urandom_range(0, 3));
  endtask

  task automatic new_dc();
    dc_pend = 1'b1;
    dc_wr   = 1'($urandom_range(0, 1));
    dc_a    = AW'($urandom_range(0, 63)) << 4;
    dc_d    = {$urandom, $urandom, $urandom, $urandom};
    dc_sz   = access_size_t'($urandom_range(0, 3));
  endtask

  initial begin : watchdog
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected end of test");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : main
    bit            w;
    logic [DW-1:0] g;
    logic [3:0]    seen;
    int            t0;

    rst_n = 1'b0;
    drive_ports();
    repeat (3) @(negedge clk);
    check("rst_mem_ctl", {bus.rd_req_valid_o, bus.wr_req_valid_o, bus.req_is_instr_o,
                          bus.access_size_o}, '0);
    check("rst_address", bus.address_o, '0);
    check("rst_wr_data", bus.wr_data_o, '0);
    check("rst_pulses", {pulses_now(), bus.ic_req_ready_o, bus.dc_req_ready_o}, '0);
    check("rst_ic_data", bus.ic_resp_data_o, '0);
    check("rst_dc_data", bus.dc_resp_data_o, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Both ports valid from reset: dcache wins the first tie, then alternate
    ic_pend = 1'b1; ic_a = 'h40;  ic_sz = SZ_LINE;
    dc_pend = 1'b1; dc_wr = 1'b0; dc_a = 'h300; dc_sz = SZ_WORD;
    for (int i = 0; i < 4; i++) begin
      txn(0, w, g);
      check("grant_order", w, i % 2);
      if (w) begin ic_pend = 1'b1; ic_a = ic_a + 'h10; end
      else   begin dc_pend = 1'b1; dc_a = dc_a + 'h10; end
    end
    ic_pend = 1'b0;
    dc_pend = 1'b0;

    ic_pend = 1'b1; ic_a = 'h40; ic_sz = SZ_LINE;
    txn(0, w, g);
    check("ic_line_40", g, 128'h0F0E0D0C0B0A09080706050403020100);

    dc_pend = 1'b1; dc_wr = 1'b1; dc_a = 'h80; dc_d = {16{8'hA5}}; dc_sz = SZ_LINE;
    txn(3, w, g);
    dc_pend = 1'b1; dc_wr = 1'b0;
    txn(4, w, g);
    check("dc_line_80", g, {16{8'hA5}});

    // Silent memory plus a mismatched-tag stray: read must time out
    env_suppress = 1'b1;
    ic_pend = 1'b1; ic_a = 'h500;
    txn(3, w, g);
    env_suppress = 1'b0;
    dc_pend = 1'b1; dc_wr = 1'b0; dc_a = 'h80;
    txn(0, w, g);

    // Reset in RD_WAIT, five cycles after issue
    ic_pend = 1'b1; ic_a = 'h600; ic_sz = SZ_LINE;
    drive_ports();
    #1;
    check("rstmid_ready", bus.ic_req_ready_o, 1'b1);
    t0 = cyc;
    @(negedge clk);
    ic_pend = 1'b0;
    drive_ports();
    repeat (5) @(negedge clk);
    bus.ic_req_valid_i = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rstmid_ctl", {bus.rd_req_valid_o, bus.wr_req_valid_o, bus.req_is_instr_o,
                         bus.access_size_o, bus.ic_req_ready_o, bus.dc_req_ready_o}, '0);
    check("rstmid_pulses", pulses_now(), '0);
    check("rstmid_ic_data", bus.ic_resp_data_o, '0);
    @(negedge clk);
    bus.ic_req_valid_i = 1'b0;
    rst_n = 1'b1;
    m_last_ic = 1'b1;
    seen = '0;
    while (cyc < t0 + 16) begin
      @(negedge clk);
      seen = seen | pulses_now();
    end
    check("rstmid_stray", seen, '0);
    ic_pend = 1'b1; ic_a = 'h600;
    txn(0, w, g);

    for (int n = 0; n < 40; n++) begin
      if (!ic_pend && $urandom_range(0, 1) == 1) new_ic();
      if (!dc_pend && $urandom_range(0, 1) == 1) new_dc();
      if (!ic_pend && !dc_pend) new_dc();
      txn(($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 5)) : 0, w, g);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
